hud_layer_mux: RTL and testbench

HUD_LAYER_MUX -- requirements
Module: hud_layer_mux

---
 rtl/hud_pkg.sv | 17 +
 rtl/hud_blink_gen.sv | 52 +++++
 rtl/hud_layer_mux.sv | 144 ++++++++++++++
 tb/tb_hud_layer_mux.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared types and defaults for the HUD layer mux
//
// Purpose: configuration FSM state type and default colour constants used by
//          hud_layer_mux and its blink generator.
// Ports:   none (package).

package hud_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_e;

    localparam int         RGB_W_DEF       = 8;
    localparam logic [7:0] TRANSPARENT_DEF = 8'hFF;

endpackage

// File: rtl/hud_blink_gen.sv
// rtl/hud_blink_gen.sv - frame counter and blink phase generator
//
// Purpose: counts frame_tick pulses; every BLINK_FRAMES ticks the counter
//          wraps to 0 and blink_phase toggles. Phase starts at 1 (visible).
// Ports:
//   clk         in  system clock, rising edge
//   reset       in  synchronous, active-high
//   frame_tick  in  one-cycle pulse at the start of each frame
//   blink_phase out 1 = blinking layers are shown, 0 = hidden

import hud_pkg::*;

module hud_blink_gen #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    output logic blink_phase
);

    localparam logic [7:0] LAST_COUNT = 8'(BLINK_FRAMES - 1);

    logic [7:0] count_q, count_d;
    logic       phase_q, phase_d;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (count_q == LAST_COUNT) begin
                count_d = 8'd0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/hud_layer_mux.sv
// rtl/hud_layer_mux.sv - prioritised HUD overlay layer selector
//
// Purpose: picks the lowest-index eligible overlay layer per pixel and
//          registers its colour; layer enable/blink masks are written through
//          a shadow register that only takes effect on a frame boundary.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   pixel_valid            current cycle carries a pixel
//   frame_tick             start-of-frame pulse
//   layer_req / layer_rgb  per-layer draw request and colour
//   cfg_valid / cfg_ready  configuration write handshake
//   cfg_enable / cfg_blink requested enable and blink masks
//   rgb_out, draw_out, layer_idx, out_valid  registered selection result

import hud_pkg::*;

module hud_layer_mux #(
    parameter int                 NUM_LAYERS   = 8,
    parameter int                 RGB_W        = RGB_W_DEF,
    parameter logic [RGB_W-1:0]   TRANSPARENT  = TRANSPARENT_DEF,
    parameter int                 BLINK_FRAMES = 30,
    localparam int                IDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pixel_valid,
    input  logic                        frame_tick,
    input  logic [NUM_LAYERS-1:0]       layer_req,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [NUM_LAYERS-1:0]       cfg_enable,
    input  logic [NUM_LAYERS-1:0]       cfg_blink,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        draw_out,
    output logic [IDX_W-1:0]            layer_idx,
    output logic                        out_valid
);

    cfg_state_e            state_q, state_d;
    logic [NUM_LAYERS-1:0] act_en_q, act_en_d;
    logic [NUM_LAYERS-1:0] act_bl_q, act_bl_d;
    logic [NUM_LAYERS-1:0] sh_en_q, sh_en_d;
    logic [NUM_LAYERS-1:0] sh_bl_q, sh_bl_d;
    logic [RGB_W-1:0]      rgb_q, rgb_d;
    logic                  draw_q, draw_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;

    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] eligible;

    hud_blink_gen #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .blink_phase(blink_phase)
    );

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eligible[i] = layer_req[i] && act_en_q[i]
                        && (layer_rgb[i*RGB_W +: RGB_W] != TRANSPARENT)
                        && (!act_bl_q[i] || blink_phase);
        end
    end

    // Walk from the lowest priority upwards so the lowest eligible index is
    // the last assignment and therefore wins.
    always_comb begin
        draw_d = 1'b0;
        idx_d  = '0;
        rgb_d  = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                draw_d = 1'b1;
                idx_d  = IDX_W'(i);
                rgb_d  = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
        valid_d = pixel_valid;
    end

    // A frame_tick in IDLE does nothing to the active masks, so a write that
    // lands on the same cycle as a tick waits for the next frame.
    always_comb begin
        state_d  = state_q;
        act_en_d = act_en_q;
        act_bl_d = act_bl_q;
        sh_en_d  = sh_en_q;
        sh_bl_d  = sh_bl_q;
        case (state_q)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    sh_en_d = cfg_enable;
                    sh_bl_d = cfg_blink;
                    state_d = CFG_PENDING;
                end
            end
            CFG_PENDING: begin
                if (frame_tick) begin
                    act_en_d = sh_en_q;
                    act_bl_d = sh_bl_q;
                    state_d  = CFG_IDLE;
                end
            end
            default: state_d = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CFG_IDLE;
            act_en_q <= '1;
            act_bl_q <= '0;
            sh_en_q  <= '1;
            sh_bl_q  <= '0;
            rgb_q    <= '0;
            draw_q   <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            act_en_q <= act_en_d;
            act_bl_q <= act_bl_d;
            sh_en_q  <= sh_en_d;
            sh_bl_q  <= sh_bl_d;
            rgb_q    <= rgb_d;
            draw_q   <= draw_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
        end
    end

    assign cfg_ready = (state_q == CFG_IDLE);
    assign rgb_out   = rgb_q;
    assign draw_out  = draw_q;
    assign layer_idx = idx_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_hud_layer_mux.sv
// tb/tb_hud_layer_mux.sv - self-checking bench for hud_layer_mux

module tb_hud_layer_mux;

    localparam int NL = 8;
    localparam int W  = 8;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset, pixel_valid, frame_tick, cfg_valid;
    logic        cfg_ready, draw_out, out_valid;
    logic [7:0]  layer_req, cfg_enable, cfg_blink, rgb_out;
    logic [63:0] layer_rgb;
    logic [2:0]  layer_idx;

    always #5 clk = ~clk;

    hud_layer_mux #(
        .NUM_LAYERS  (NL),
        .RGB_W       (W),
        .TRANSPARENT (8'hFF),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_valid(pixel_valid),
        .frame_tick (frame_tick),
        .layer_req  (layer_req),
        .layer_rgb  (layer_rgb),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_enable (cfg_enable),
        .cfg_blink  (cfg_blink),
        .rgb_out    (rgb_out),
        .draw_out   (draw_out),
        .layer_idx  (layer_idx),
        .out_valid  (out_valid)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: masks, shadow copy, a pending flag and a count of
    // frames since reset from which the blink phase is derived.
    logic [7:0] m_en, m_bl, m_sen, m_sbl;
    bit         m_pend;
    int         m_frames;
    logic [7:0] m_rgb;
    bit         m_draw;
    int         m_idx;
    bit         m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit phase;
        if (reset) begin
            m_en = 8'hFF; m_bl = 8'h00; m_sen = 8'hFF; m_sbl = 8'h00;
            m_pend = 0; m_frames = 0;
            m_rgb = 8'h00; m_draw = 0; m_idx = 0; m_valid = 0;
        end else begin
            phase  = ((m_frames / BF) % 2) == 0;
            m_draw = 0; m_rgb = 8'h00; m_idx = 0;
            for (int i = 0; i < NL; i++) begin
                if (!m_draw && layer_req[i] && m_en[i] && layer_rgb[i*W +: W] != 8'hFF
                    && (!m_bl[i] || phase)) begin
                    m_draw = 1; m_rgb = layer_rgb[i*W +: W]; m_idx = i;
                end
            end
            m_valid = pixel_valid;
            if (m_pend) begin
                if (frame_tick) begin
                    m_en = m_sen; m_bl = m_sbl; m_pend = 0;
                end
            end else if (cfg_valid) begin
                m_sen = cfg_enable; m_sbl = cfg_blink; m_pend = 1;
            end
            if (frame_tick) m_frames++;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, " rgb_out"},   64'(rgb_out),   64'(m_rgb));
        chk({tag, " draw_out"},  64'(draw_out),  64'(m_draw));
        chk({tag, " layer_idx"}, 64'(layer_idx), 64'(m_idx));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, " cfg_ready"}, 64'(cfg_ready), 64'(!m_pend));
    endtask

    task automatic do_reset();
        reset = 1; step("reset"); reset = 0;
    endtask

    typedef struct {
        logic [7:0]  req;
        logic [63:0] rgb;
        logic [7:0]  e_rgb;
        logic        e_draw;
        logic [2:0]  e_idx;
    } vec_t;

    vec_t tbl[6];
    logic [8:0] vis;

    initial begin
        reset = 1; pixel_valid = 0; frame_tick = 0; cfg_valid = 0;
        layer_req = 8'h00; layer_rgb = 64'h0; cfg_enable = 8'h00; cfg_blink = 8'h00;
        step("reset0");
        step("reset1");
        chk("reset rgb_out",   64'(rgb_out),   64'h0);
        chk("reset draw_out",  64'(draw_out),  64'h0);
        chk("reset layer_idx", 64'(layer_idx), 64'h0);
        chk("reset out_valid", 64'(out_valid), 64'h0);
        chk("reset cfg_ready", 64'(cfg_ready), 64'h1);
        reset = 0;

        tbl[0] = '{8'h06, 64'h0000_0000_00E0_1C00, 8'h1C, 1'b1, 3'd1};
        tbl[1] = '{8'h06, 64'h0000_0000_00E0_FF00, 8'hE0, 1'b1, 3'd2};
        tbl[2] = '{8'h00, 64'h1122_3344_5566_7788, 8'h00, 1'b0, 3'd0};
        tbl[3] = '{8'hFF, 64'h0000_0000_33FF_FFFF, 8'h33, 1'b1, 3'd3};
        tbl[4] = '{8'h80, 64'h5A00_0000_0000_0000, 8'h5A, 1'b1, 3'd7};
        tbl[5] = '{8'h81, 64'h7700_0000_0000_0000, 8'h00, 1'b1, 3'd0};
        pixel_valid = 1;
        for (int v = 0; v < 6; v++) begin
            layer_req = tbl[v].req;
            layer_rgb = tbl[v].rgb;
            step($sformatf("vec%0d", v));
            chk($sformatf("vec%0d rgb", v),  64'(rgb_out),   64'(tbl[v].e_rgb));
            chk($sformatf("vec%0d draw", v), 64'(draw_out),  64'(tbl[v].e_draw));
            chk($sformatf("vec%0d idx", v),  64'(layer_idx), 64'(tbl[v].e_idx));
        end

        // out_valid follows a single pixel_valid pulse one cycle later
        layer_req = 8'h00;
        pixel_valid = 1; step("pv1");
        chk("pv pulse high", 64'(out_valid), 64'h1);
        pixel_valid = 0; step("pv0");
        chk("pv pulse low", 64'(out_valid), 64'h0);
        chk("no req draw", 64'(draw_out), 64'h0);

        // mid-frame enable write, ignored second write, apply on frame_tick
        pixel_valid = 1; layer_req = 8'h06; layer_rgb = 64'h0000_0000_00E0_1C00;
        step("cfg0");
        cfg_valid = 1; cfg_enable = 8'hFD; cfg_blink = 8'h00; step("cfg1");
        chk("cfg pending ready", 64'(cfg_ready), 64'h0);
        cfg_enable = 8'h00; step("cfg2");
        cfg_valid = 0;
        for (int k = 0; k < 3; k++) begin
            step("cfg_wait");
            chk("cfg old mask rgb", 64'(rgb_out), 64'h1C);
        end
        frame_tick = 1; step("cfg_tick");
        chk("cfg tick rgb", 64'(rgb_out), 64'h1C);
        chk("cfg tick ready", 64'(cfg_ready), 64'h1);
        frame_tick = 0; step("cfg_after");
        chk("cfg new mask rgb", 64'(rgb_out), 64'hE0);
        chk("cfg new mask idx", 64'(layer_idx), 64'h2);

        // write coinciding with a tick in IDLE waits for the next tick
        cfg_valid = 1; cfg_enable = 8'hFF; frame_tick = 1; step("same0");
        cfg_valid = 0; frame_tick = 0; step("same1");
        chk("same-cycle not applied", 64'(rgb_out), 64'hE0);
        frame_tick = 1; step("same2");
        frame_tick = 0; step("same3");
        chk("same-cycle applied", 64'(rgb_out), 64'h1C);

        // reset while pending drops the pending mask
        cfg_valid = 1; cfg_enable = 8'h00; step("rp0");
        cfg_valid = 0;
        chk("rp pending", 64'(cfg_ready), 64'h0);
        do_reset();
        chk("rp ready", 64'(cfg_ready), 64'h1);
        frame_tick = 1; step("rp1");
        frame_tick = 0; step("rp2");
        chk("rp mask kept rgb", 64'(rgb_out), 64'h1C);
        chk("rp mask kept draw", 64'(draw_out), 64'h1);

        // blink on layer 1 with two frames per half-period
        do_reset();
        layer_req = 8'h02;
        cfg_valid = 1; cfg_enable = 8'hFF; cfg_blink = 8'h02; step("bl0");
        cfg_valid = 0; cfg_blink = 8'h00;
        frame_tick = 1; step("bl_tick");
        frame_tick = 0; step("bl_frame");
        vis = 9'b100110010;
        chk("blink frame1", 64'(draw_out), 64'(vis[1]));
        for (int k = 2; k <= 8; k++) begin
            frame_tick = 1; step("bl_tick");
            frame_tick = 0; step("bl_frame");
            chk($sformatf("blink frame%0d", k), 64'(draw_out), 64'(vis[k]));
        end

        // randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 79) == 0);
            pixel_valid = 1'($urandom);
            frame_tick  = ($urandom_range(0, 5) == 0);
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_enable  = 8'($urandom);
            cfg_blink   = 8'($urandom);
            layer_req   = 8'($urandom);
            for (int i = 0; i < NL; i++)
                layer_rgb[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step("rand");
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
